// File: rtl/spm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spm_arb_pkg
// Purpose  : Shared types and constants for the two-port SPM arbiter.
// Revision : 1.0
// ============================================================================
package spm_arb_pkg;

    localparam int NUM_REQ      = 2;
    localparam int LOCK_TIMEOUT = 16;
    localparam int ADDR_W       = 18;
    localparam int DATA_W       = 32;
    localparam int BEN_W        = 4;
    localparam int LOCK_CNT_W   = 5;

    typedef logic [$clog2(NUM_REQ)-1:0] reqId_t;

    typedef struct packed {
        logic   valid;
        reqId_t id;
    } rdTag_t;

    localparam logic [1:0] UNLOCKED = 2'd0;
    localparam logic [1:0] LOCKED0  = 2'd1;
    localparam logic [1:0] LOCKED1  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/spm_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spm_port_arbiter_if
// Purpose  : Requester and SPM-side signals of the two-port SPM arbiter.
// Revision : 1.0
// ============================================================================
interface spm_port_arbiter_if;
    import spm_arb_pkg::*;

    logic              req0, we0, lock0, gnt0, rvalid0;
    logic [ADDR_W-1:0] addr0;
    logic [BEN_W-1:0]  ben0;
    logic [DATA_W-1:0] wdata0, rdata0;

    logic              req1, we1, lock1, gnt1, rvalid1;
    logic [ADDR_W-1:0] addr1;
    logic [BEN_W-1:0]  ben1;
    logic [DATA_W-1:0] wdata1, rdata1;

    logic              spmCs, spmWe;
    logic [ADDR_W-1:0] spmAddress;
    logic [BEN_W-1:0]  spmByteEnables;
    logic [DATA_W-1:0] dataToSpm, dataFromSpm;

    modport slave (
        input  req0, we0, lock0, addr0, ben0, wdata0,
        input  req1, we1, lock1, addr1, ben1, wdata1,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
        output spmCs, spmWe, spmAddress, spmByteEnables, dataToSpm,
        input  dataFromSpm
    );

    modport master (
        output req0, we0, lock0, addr0, ben0, wdata0,
        output req1, we1, lock1, addr1, ben1, wdata1,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
        input  spmCs, spmWe, spmAddress, spmByteEnables, dataToSpm,
        output dataFromSpm
    );

endinterface
`default_nettype wire

// File: rtl/spm_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : spm_rd_tag_pipe
// Purpose  : Fixed-depth shift register carrying {valid,id} read tags.
// Revision : 1.0
// ============================================================================
module spm_rd_tag_pipe
    import spm_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic   clock,
    input  wire logic   reset,
    input  wire rdTag_t inTag,
    output rdTag_t      outTag
);

    rdTag_t r_stage [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= inTag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign outTag = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/spm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spm_port_arbiter
// Purpose  : Round-robin, lockable arbiter of two requesters onto one SPM port.
// Revision : 1.0
// ============================================================================
module spm_port_arbiter
    import spm_arb_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input wire logic          clock,
    input wire logic          reset,
    spm_port_arbiter_if.slave bus
);

    logic [1:0]            r_state;
    logic [1:0]            w_nextState;
    logic                  r_lastWinner;
    logic [LOCK_CNT_W-1:0] r_idleCnt;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_ownerIdle;
    logic                  w_timeout;
    rdTag_t                w_inTag;
    rdTag_t                w_outTag;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= UNLOCKED;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_ownerIdle = ((r_state == LOCKED0) && !bus.req0) ||
                      ((r_state == LOCKED1) && !bus.req1);
        w_timeout   = w_ownerIdle && (r_idleCnt == LOCK_CNT_W'(LOCK_TIMEOUT - 1));
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            UNLOCKED: begin
                if (w_gnt0 && bus.lock0) begin
                    w_nextState = LOCKED0;
                end else if (w_gnt1 && bus.lock1) begin
                    w_nextState = LOCKED1;
                end
            end
            LOCKED0: begin
                if ((w_gnt0 && !bus.lock0) || w_timeout) begin
                    w_nextState = UNLOCKED;
                end
            end
            LOCKED1: begin
                if ((w_gnt1 && !bus.lock1) || w_timeout) begin
                    w_nextState = UNLOCKED;
                end
            end
            default: w_nextState = UNLOCKED;
        endcase
    end

    // Grants are suppressed during reset so the SPM port is quiet while it is held.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            case (r_state)
                UNLOCKED: begin
                    w_gnt0 = bus.req0 && (!bus.req1 || r_lastWinner);
                    w_gnt1 = bus.req1 && !w_gnt0;
                end
                LOCKED0: w_gnt0 = bus.req0;
                LOCKED1: w_gnt1 = bus.req1;
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lastWinner <= 1'b1;
        end else if (w_gnt0) begin
            r_lastWinner <= 1'b0;
        end else if (w_gnt1) begin
            r_lastWinner <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idleCnt <= '0;
        end else if (w_ownerIdle && !w_timeout) begin
            r_idleCnt <= r_idleCnt + 1'b1;
        end else begin
            r_idleCnt <= '0;
        end
    end

    always_comb begin
        bus.spmWe          = 1'b0;
        bus.spmAddress     = '0;
        bus.spmByteEnables = '0;
        bus.dataToSpm      = '0;
        if (w_gnt0) begin
            bus.spmWe          = bus.we0;
            bus.spmAddress     = bus.addr0;
            bus.spmByteEnables = bus.ben0;
            bus.dataToSpm      = bus.wdata0;
        end else if (w_gnt1) begin
            bus.spmWe          = bus.we1;
            bus.spmAddress     = bus.addr1;
            bus.spmByteEnables = bus.ben1;
            bus.dataToSpm      = bus.wdata1;
        end
    end

    assign bus.gnt0  = w_gnt0;
    assign bus.gnt1  = w_gnt1;
    assign bus.spmCs = w_gnt0 | w_gnt1;

    assign w_inTag.valid = (w_gnt0 | w_gnt1) && !bus.spmWe;
    assign w_inTag.id    = reqId_t'(w_gnt1);

    spm_rd_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_rdTagPipe (
        .clock  (clock),
        .reset  (reset),
        .inTag  (w_inTag),
        .outTag (w_outTag)
    );

    assign bus.rvalid0 = !reset && w_outTag.valid && (w_outTag.id == reqId_t'(0));
    assign bus.rvalid1 = !reset && w_outTag.valid && (w_outTag.id == reqId_t'(1));
    assign bus.rdata0  = reset ? '0 : bus.dataFromSpm;
    assign bus.rdata1  = reset ? '0 : bus.dataFromSpm;

endmodule
`default_nettype wire

// File: tb/tb_spm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spm_port_arbiter
// Purpose  : Directed self-checking bench for spm_port_arbiter with an SPM model.
// Revision : 1.0
// ============================================================================
module tb_spm_port_arbiter;
    import spm_arb_pkg::*;

    localparam int L = 2;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    spm_port_arbiter_if bus ();

    spm_port_arbiter #(
        .READ_LATENCY (L)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SPM model: byte-masked writes, reads returned L cycles after the access.
    logic [31:0] mem [0:255];
    logic [31:0] rdStage [L];

    always @(posedge clock) begin
        if (bus.spmCs && bus.spmWe) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.spmByteEnables[b]) begin
                    mem[bus.spmAddress[7:0]][8*b +: 8] <= bus.dataToSpm[8*b +: 8];
                end
            end
        end
        rdStage[0] <= (bus.spmCs && !bus.spmWe) ? mem[bus.spmAddress[7:0]] : 32'h0;
        for (int s = 1; s < L; s++) begin
            rdStage[s] <= rdStage[s-1];
        end
    end

    assign bus.dataFromSpm = rdStage[L-1];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [17:0] addr,
                          input logic [3:0] ben, input logic [31:0] wdata, input logic lock);
        bus.req0 = req; bus.we0 = we; bus.addr0 = addr;
        bus.ben0 = ben; bus.wdata0 = wdata; bus.lock0 = lock;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [17:0] addr,
                          input logic [3:0] ben, input logic [31:0] wdata, input logic lock);
        bus.req1 = req; bus.we1 = we; bus.addr1 = addr;
        bus.ben1 = ben; bus.wdata1 = wdata; bus.lock1 = lock;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive0(0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0);
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive0(1, 0, 18'h10, 4'hF, 0, 0);
        drive1(1, 1, 18'h20, 4'hF, 32'h1, 0);
        cyc();
        @(negedge clock);
        total++; if (bus.gnt0 !== 1'b0) begin bad++; $display("FAIL reset_gnt0 got=%b want=0", bus.gnt0); end
        total++; if (bus.gnt1 !== 1'b0) begin bad++; $display("FAIL reset_gnt1 got=%b want=0", bus.gnt1); end
        total++; if (bus.spmCs !== 1'b0) begin bad++; $display("FAIL reset_spmCs got=%b want=0", bus.spmCs); end
        total++; if (bus.spmWe !== 1'b0) begin bad++; $display("FAIL reset_spmWe got=%b want=0", bus.spmWe); end
        total++; if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b want=00", {bus.rvalid0, bus.rvalid1}); end
        cyc();
        reset = 1'b0;
        drive1(1, 0, 18'h20, 4'hF, 0, 0);
        @(negedge clock);
        total++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin bad++; $display("FAIL first_tie got=%b want=10", {bus.gnt0, bus.gnt1}); end
        cyc();
        drive0(0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0);
        repeat (4) cyc();
    endtask

    task automatic single_write(input logic id, input logic [17:0] addr, input logic [31:0] data);
        if (id) drive1(1, 1, addr, 4'hF, data, 0);
        else    drive0(1, 1, addr, 4'hF, data, 0);
        cyc();
        drive0(0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_round_robin();
        logic [5:0] eg0, eg1, erv0, erv1;
        eg0 = 6'b000101; eg1 = 6'b001010; erv0 = 6'b010100; erv1 = 6'b101000;
        single_write(0, 18'h10, 32'hA0A0_0010);
        single_write(1, 18'h20, 32'hB0B0_0020);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive0(k < 4, 0, 18'h10, 4'hF, 0, 0);
            drive1(k < 4, 0, 18'h20, 4'hF, 0, 0);
            @(negedge clock);
            total++; if ({bus.gnt0, bus.gnt1} !== {eg0[k], eg1[k]}) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b want=%b", k, {bus.gnt0, bus.gnt1}, {eg0[k], eg1[k]}); end
            total++; if ({bus.rvalid0, bus.rvalid1} !== {erv0[k], erv1[k]}) begin bad++; $display("FAIL rr_rvalid cyc=%0d got=%b want=%b", k, {bus.rvalid0, bus.rvalid1}, {erv0[k], erv1[k]}); end
            if (erv0[k]) begin
                total++; if (bus.rdata0 !== 32'hA0A0_0010) begin bad++; $display("FAIL rr_rdata0 cyc=%0d got=%h want=a0a00010", k, bus.rdata0); end
            end
            if (erv1[k]) begin
                total++; if (bus.rdata1 !== 32'hB0B0_0020) begin bad++; $display("FAIL rr_rdata1 cyc=%0d got=%h want=b0b00020", k, bus.rdata1); end
            end
            if (k >= 4) begin
                total++; if ({bus.spmCs, bus.spmAddress} !== 19'h0) begin bad++; $display("FAIL rr_idle_bus cyc=%0d got=%h want=0", k, {bus.spmCs, bus.spmAddress}); end
            end
            cyc();
        end
    endtask

    task automatic test_write_then_read();
        do_reset();
        drive1(1, 1, 18'h5, 4'hF, 32'hDEADBEEF, 0);
        @(negedge clock);
        total++; if ({bus.gnt1, bus.spmWe, bus.spmAddress} !== {2'b11, 18'h5}) begin bad++; $display("FAIL wr_issue got=%b/%b/%h want=1/1/5", bus.gnt1, bus.spmWe, bus.spmAddress); end
        total++; if (bus.dataToSpm !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_data got=%h want=deadbeef", bus.dataToSpm); end
        cyc();
        drive1(1, 0, 18'h5, 4'hF, 0, 0);
        @(negedge clock);
        total++; if ({bus.gnt1, bus.spmWe} !== 2'b10) begin bad++; $display("FAIL rd_issue got=%b want=10", {bus.gnt1, bus.spmWe}); end
        cyc();
        drive1(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        total++; if (bus.rvalid1 !== 1'b0) begin bad++; $display("FAIL raw_early got=%b want=0", bus.rvalid1); end
        cyc();
        @(negedge clock);
        total++; if ({bus.rvalid0, bus.rvalid1} !== 2'b01) begin bad++; $display("FAIL raw_rvalid got=%b want=01", {bus.rvalid0, bus.rvalid1}); end
        total++; if (bus.rdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_rdata got=%h want=deadbeef", bus.rdata1); end
        repeat (3) cyc();
    endtask

    task automatic test_lock();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive0(k < 4, 0, 18'h10, 4'hF, 0, k < 3);
            drive1(1, 0, 18'h20, 4'hF, 0, 0);
            @(negedge clock);
            if (k < 4) begin
                total++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin bad++; $display("FAIL lock_hold cyc=%0d got=%b want=10", k, {bus.gnt0, bus.gnt1}); end
            end else begin
                total++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin bad++; $display("FAIL lock_release got=%b want=01", {bus.gnt0, bus.gnt1}); end
            end
            cyc();
        end
        drive1(0, 0, 0, 0, 0, 0);
        repeat (4) cyc();
    endtask

    task automatic test_lock_timeout();
        do_reset();
        for (int k = 0; k < 18; k++) begin
            drive0(k == 0, 0, 18'h10, 4'hF, 0, 1);
            drive1(1, 0, 18'h20, 4'hF, 0, 0);
            @(negedge clock);
            if (k == 0) begin
                total++; if (bus.gnt0 !== 1'b1) begin bad++; $display("FAIL to_lock_gnt got=%b want=1", bus.gnt0); end
            end else if (k <= 16) begin
                total++; if ({bus.gnt0, bus.gnt1} !== 2'b00) begin bad++; $display("FAIL to_blocked cyc=%0d got=%b want=00", k, {bus.gnt0, bus.gnt1}); end
            end else begin
                total++; if (bus.gnt1 !== 1'b1) begin bad++; $display("FAIL to_expire got=%b want=1", bus.gnt1); end
                total++; if (dut.r_state !== UNLOCKED) begin bad++; $display("FAIL to_state got=%0d want=%0d", dut.r_state, UNLOCKED); end
            end
            cyc();
        end
        drive0(0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0);
        repeat (4) cyc();
    endtask

    task automatic test_reset_midread();
        do_reset();
        drive0(1, 0, 18'h10, 4'hF, 0, 0);
        @(negedge clock);
        total++; if (bus.gnt0 !== 1'b1) begin bad++; $display("FAIL mr_gnt got=%b want=1", bus.gnt0); end
        cyc();
        reset = 1'b1;
        drive1(1, 1, 18'h33, 4'hF, 32'h5, 0);
        @(negedge clock);
        total++; if ({bus.gnt0, bus.gnt1, bus.spmCs, bus.spmWe, bus.rvalid0, bus.rvalid1} !== 6'b0)
            begin bad++; $display("FAIL mr_outputs got=%b want=000000", {bus.gnt0, bus.gnt1, bus.spmCs, bus.spmWe, bus.rvalid0, bus.rvalid1}); end
        total++; if ({bus.spmAddress, bus.dataToSpm} !== 50'h0) begin bad++; $display("FAIL mr_bus got=%h want=0", {bus.spmAddress, bus.dataToSpm}); end
        cyc();
        reset = 1'b0;
        drive0(0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            total++; if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin bad++; $display("FAIL mr_stale cyc=%0d got=%b want=00", k, {bus.rvalid0, bus.rvalid1}); end
            cyc();
        end
    endtask

    task automatic test_byte_enable();
        do_reset();
        drive0(1, 1, 18'h9, 4'hF, 32'h11223344, 0);
        cyc();
        drive0(1, 1, 18'h9, 4'h3, 32'hAABBCCDD, 0);
        @(negedge clock);
        total++; if ({bus.gnt0, bus.spmByteEnables} !== 5'h13) begin bad++; $display("FAIL be_issue got=%h want=13", {bus.gnt0, bus.spmByteEnables}); end
        cyc();
        drive0(1, 0, 18'h9, 4'hF, 0, 0);
        cyc();
        drive0(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        total++; if (bus.rvalid0 !== 1'b0) begin bad++; $display("FAIL be_early got=%b want=0", bus.rvalid0); end
        cyc();
        @(negedge clock);
        total++; if (bus.rvalid0 !== 1'b1) begin bad++; $display("FAIL be_rvalid got=%b want=1", bus.rvalid0); end
        total++; if (bus.rdata0 !== 32'h1122CCDD) begin bad++; $display("FAIL be_rdata got=%h want=1122ccdd", bus.rdata0); end
        repeat (3) cyc();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive0(0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0);
        test_reset();
        test_round_robin();
        test_write_then_read();
        test_lock();
        test_lock_timeout();
        test_reset_midread();
        test_byte_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
